// File: rtl/bc_msg_broadcast_arbiter.sv
// Cluster broadcast arbiter: per-core hold registers, round-robin pick, one-cycle rebroadcast.
// Optional BC_MSG_SELF_FILTER_EN masks the delivery pulse to the originating core.
module bc_msg_broadcast_arbiter #(
  parameter int CORE_COUNT    = 8,
  parameter int CORE_ID_WIDTH = 3,
  parameter int MSG_WIDTH     = 47
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CORE_COUNT*MSG_WIDTH-1:0] bc_msg_out,
  input  logic [CORE_COUNT-1:0]           bc_msg_out_valid,
  output logic [CORE_COUNT-1:0]           bc_msg_out_ready,
  output logic [MSG_WIDTH-1:0]            bc_msg_in,
  output logic [CORE_COUNT-1:0]           bc_msg_in_valid,
  output logic [CORE_ID_WIDTH-1:0]        bc_msg_src,
  output logic [31:0]                     bc_msg_count
);

  logic [CORE_COUNT-1:0]    hold_valid;
  logic [MSG_WIDTH-1:0]     hold_data [CORE_COUNT];
  logic [CORE_ID_WIDTH-1:0] rr_ptr;
  logic [CORE_ID_WIDTH-1:0] gnt_idx;
  logic [CORE_ID_WIDTH-1:0] rr_next;
  logic [CORE_COUNT-1:0]    grant;
  logic [CORE_COUNT-1:0]    pulse;
  logic                     gnt_any;
  int                       idx;

  // First held entry at or after rr_ptr, modulo CORE_COUNT.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < CORE_COUNT; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= CORE_COUNT) idx = idx - CORE_COUNT;
      if (!gnt_any && hold_valid[CORE_ID_WIDTH'(idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = CORE_ID_WIDTH'(idx);
      end
    end
  end

  assign grant = gnt_any ? (CORE_COUNT'(1) << gnt_idx) : '0;

  assign rr_next = (gnt_idx == CORE_ID_WIDTH'(CORE_COUNT - 1))
                 ? '0 : gnt_idx + CORE_ID_WIDTH'(1);

  assign bc_msg_out_ready = ~hold_valid | grant;

`ifdef BC_MSG_SELF_FILTER_EN
  assign pulse = ~grant;
`else
  assign pulse = '1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid      <= '0;
      rr_ptr          <= '0;
      bc_msg_in       <= '0;
      bc_msg_in_valid <= '0;
      bc_msg_src      <= '0;
      bc_msg_count    <= '0;
      for (int i = 0; i < CORE_COUNT; i++) hold_data[i] <= '0;
    end else begin
      // A new accept on the granted core overwrites the slot in the same edge.
      for (int i = 0; i < CORE_COUNT; i++) begin
        if (bc_msg_out_valid[i] && bc_msg_out_ready[i]) begin
          hold_data[i]  <= bc_msg_out[i*MSG_WIDTH +: MSG_WIDTH];
          hold_valid[i] <= 1'b1;
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
      if (gnt_any) begin
        rr_ptr          <= rr_next;
        bc_msg_in       <= hold_data[gnt_idx];
        bc_msg_src      <= gnt_idx;
        bc_msg_in_valid <= pulse;
        bc_msg_count    <= bc_msg_count + 32'd1;
      end else begin
        bc_msg_in_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bc_msg_broadcast_arbiter.sv
// Scoreboard bench for bc_msg_broadcast_arbiter.
// Per-core expected payload queues are filled on handshake and drained on each pulse.
module tb_bc_msg_broadcast_arbiter;
  localparam int N  = 8;
  localparam int IW = 3;
  localparam int MW = 47;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N*MW-1:0] msg_out = '0;
  logic [N-1:0]  out_valid = '0;
  logic [N-1:0]  out_ready;
  logic [MW-1:0] msg_in;
  logic [N-1:0]  in_valid;
  logic [IW-1:0] src;
  logic [31:0]   count;

  bc_msg_broadcast_arbiter #(
    .CORE_COUNT(N), .CORE_ID_WIDTH(IW), .MSG_WIDTH(MW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bc_msg_out(msg_out),
    .bc_msg_out_valid(out_valid),
    .bc_msg_out_ready(out_ready),
    .bc_msg_in(msg_in),
    .bc_msg_in_valid(in_valid),
    .bc_msg_src(src),
    .bc_msg_count(count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [MW-1:0] exp_q [N][$];
  int            src_log[$];
  int            n_chk = 0;
  int            n_pass = 0;
  int            last_obs = 0;
  int            hs_cyc = 0;
  logic [N-1:0]  last_vld = '0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [N-1:0] exp_vld(int s);
`ifdef BC_MSG_SELF_FILTER_EN
    return ~(N'(1) << s);
`else
    return '1;
`endif
  endfunction

  function automatic int pending();
    int p = 0;
    for (int i = 0; i < N; i++) p += exp_q[i].size();
    return p;
  endfunction

  always @(negedge clk) begin
    if (rst_n && in_valid != '0) begin
      last_obs = cyc;
      last_vld = in_valid;
      src_log.push_back(int'(src));
      chk("pulse_vld", 64'(in_valid), 64'(exp_vld(int'(src))));
      if (exp_q[src].size() == 0) chk("unexpected_msg", 64'(src), 64'hFF);
      else chk("payload", 64'(msg_in), 64'(exp_q[src].pop_front()));
    end
  end

  task automatic send(logic [N-1:0] mask, logic [MW-1:0] base, logic [MW-1:0] stride);
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (mask[i]) msg_out[i*MW +: MW] = base + stride * MW'(i);
    out_valid = mask;
    #1;
    for (int i = 0; i < N; i++)
      if (mask[i]) begin
        chk($sformatf("ready%0d", i), 64'(out_ready[i]), 64'd1);
        exp_q[i].push_back(base + stride * MW'(i));
      end
    hs_cyc = cyc;
    @(posedge clk);
    #1 out_valid = '0;
  endtask

  task automatic drain(int budget);
    int t = 0;
    while (pending() != 0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    if (pending() != 0) chk("drain_timeout", 64'(pending()), 64'd0);
    repeat (3) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) exp_q[i].delete();
    src_log.delete();
    rst_n = 1'b1;
  endtask

  int d2, d5, low2, low5, maxlow, n_acc;
  bit ok;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(in_valid), 64'd0);
    chk("rst_msg", 64'(msg_in), 64'd0);
    chk("rst_src", 64'(src), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(out_ready), 64'hFF);
    rst_n = 1'b1;

    // single message, latency 2
    send(8'h08, 47'h1234, 47'h0);
    drain(20);
    chk("t1_latency", 64'(last_obs - hs_cyc), 64'd2);
    chk("t1_src", 64'(src), 64'd3);
    chk("t1_msg", 64'(msg_in), 64'h1234);
    chk("t1_count", 64'(count), 64'd1);
    chk("t1_nmsg", 64'(src_log.size()), 64'd1);

    // all cores at once
    do_reset();
    send(8'hFF, 47'h100, 47'h10);
    drain(40);
    chk("t2_nmsg", 64'(src_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < src_log.size(); i++)
      chk($sformatf("t2_order%0d", i), 64'(src_log[i]), 64'(i));
    chk("t2_span", 64'(last_obs - hs_cyc), 64'd9);
    chk("t2_count", 64'(count), 64'd8);

    // cores 2 and 5 streaming
    do_reset();
    d2 = 'h2000; d5 = 'h5000;
    low2 = 0; low5 = 0; maxlow = 0; n_acc = 0;
    for (int it = 0; it < 20; it++) begin
      @(negedge clk);
      msg_out[2*MW +: MW] = MW'(d2);
      msg_out[5*MW +: MW] = MW'(d5);
      out_valid = 8'h24;
      #1;
      if (out_ready[2]) begin
        exp_q[2].push_back(MW'(d2)); d2++; n_acc++; low2 = 0;
      end else low2++;
      if (out_ready[5]) begin
        exp_q[5].push_back(MW'(d5)); d5++; n_acc++; low5 = 0;
      end else low5++;
      if (low2 > maxlow) maxlow = low2;
      if (low5 > maxlow) maxlow = low5;
      @(posedge clk);
    end
    #1 out_valid = '0;
    drain(40);
    chk("t3_ready_low", 64'(maxlow), 64'd1);
    chk("t3_nmsg", 64'(src_log.size()), 64'(n_acc));
    chk("t3_first", 64'(src_log.size() > 0 ? src_log[0] : -1), 64'd2);
    ok = 1'b1;
    for (int i = 1; i < src_log.size(); i++)
      if (src_log[i] == src_log[i-1] || (src_log[i] != 2 && src_log[i] != 5)) ok = 1'b0;
    chk("t3_alternate", 64'(ok), 64'd1);
    chk("t3_count", 64'(count), 64'(n_acc));

    // pointer wrap from 7
    do_reset();
    send(8'h40, 47'h600, 47'h0);
    drain(20);
    send(8'h80, 47'h700, 47'h0);
    drain(20);
    src_log.delete();
    send(8'h41, 47'hA00, 47'h6);
    drain(20);
    chk("t4_nmsg", 64'(src_log.size()), 64'd2);
    chk("t4_first", 64'(src_log.size() > 0 ? src_log[0] : -1), 64'd0);
    chk("t4_second", 64'(src_log.size() > 1 ? src_log[1] : -1), 64'd6);
    chk("t4_count", 64'(count), 64'd4);

    // reset while core 4 is held
    send(8'h10, 47'h444, 47'h0);
    rst_n = 1'b0;
    #1;
    chk("t5_valid", 64'(in_valid), 64'd0);
    chk("t5_msg", 64'(msg_in), 64'd0);
    chk("t5_src", 64'(src), 64'd0);
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_ready", 64'(out_ready), 64'hFF);
    exp_q[4].delete();
    src_log.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("t5_no_bcast", 64'(src_log.size()), 64'd0);
    chk("t5_count_after", 64'(count), 64'd0);

    // source filtering pattern
    send(8'h02, 47'h1111, 47'h0);
    drain(20);
`ifdef BC_MSG_SELF_FILTER_EN
    chk("t6_pattern", 64'(last_vld), 64'hFD);
`else
    chk("t6_pattern", 64'(last_vld), 64'hFF);
`endif
    chk("t6_src", 64'(src), 64'd1);
    chk("t6_count", 64'(count), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
